// File: rtl/booth4_seq_mult_if.sv
// Handshake and operand/result bundle for the radix-4 Booth sequential multiplier.
// The host drives start and the operands; the multiplier returns busy, done and product.
interface booth4_seq_mult_if #(
    parameter int N = 8
);
    logic                  start;
    logic signed [N-1:0]   multiplicand;
    logic signed [N-1:0]   multiplier;
    logic                  busy;
    logic                  done;
    logic signed [2*N-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier.
// One bit-triplet of the multiplier is recoded per cycle; after N/2 iterations
// {acc[N-1:0], q} holds the exact 2N-bit two's-complement product.
module booth4_seq_mult #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    booth4_seq_mult_if.slave   bus
);
    localparam int CNT_W = $clog2(N / 2) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [N-1:0]   m_q, m_d;
    logic signed [N+1:0]   acc_q, acc_d;
    logic [N-1:0]          q_q, q_d;
    logic                  qm1_q, qm1_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic signed [2*N-1:0] prod_q, prod_d;

    logic signed [N+1:0]   addend;
    logic signed [N+1:0]   sum;
    logic signed [N+1:0]   acc_sh;
    logic [N-1:0]          q_sh;

    // Booth recoding of {q[1], q[0], q_m1} into 0, +-M or +-2M at accumulator width.
    // The two extra accumulator bits keep -(-2^(N-1)) and 2M representable.
    function automatic logic signed [N+1:0] booth_addend(input logic [2:0] sel,
                                                         input logic signed [N-1:0] m);
        logic signed [N+1:0] m1;
        logic signed [N+1:0] m2;
        m1 = {{2{m[N-1]}}, m};
        m2 = m1 <<< 1;
        case (sel)
            3'b001, 3'b010: booth_addend = m1;
            3'b011:         booth_addend = m2;
            3'b100:         booth_addend = ~m2 + (N+2)'(1);
            3'b101, 3'b110: booth_addend = ~m1 + (N+2)'(1);
            default:        booth_addend = '0;
        endcase
    endfunction

    // Registers: control and datapath state, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    // Next-state logic: operand capture, one add-and-shift per RUN cycle, product capture on the last one.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        addend  = booth_addend({q_q[1:0], qm1_q}, m_q);
        sum     = acc_q + addend;
        // Arithmetic shift of {acc, q, q_m1} by two: acc sign fills the vacated MSBs.
        acc_sh  = sum >>> 2;
        q_sh    = {sum[1:0], q_q[N-1:2]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    m_d     = bus.multiplicand;
                    acc_d   = '0;
                    q_d     = bus.multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                qm1_d = q_q[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    prod_d  = {acc_sh[N-1:0], q_sh};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = prod_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Self-checking bench for booth4_seq_mult (N=8): directed corner cases plus
// randomized operand pairs against a cycle-level behavioural reference.
module tb_booth4_seq_mult;
    localparam int N = 8;

    logic clk;
    logic rst;

    booth4_seq_mult_if #(.N(N)) bus ();

    booth4_seq_mult #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: product is the plain signed product of the operands captured on
    // an accepted start; busy for N/2 cycles afterwards, then one done cycle.
    bit                    live = 1'b0;
    int                    rem = 0;
    bit                    exp_done = 1'b0;
    logic signed [2*N-1:0] exp_prod = '0;
    logic signed [2*N-1:0] pend = '0;

    always @(posedge clk) begin
        live <= 1'b1;
        if (rst) begin
            rem      <= 0;
            exp_done <= 1'b0;
            exp_prod <= '0;
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                exp_done <= 1'b1;
                exp_prod <= pend;
            end
        end else begin
            exp_done <= 1'b0;
            if (bus.start) begin
                rem  <= N / 2;
                pend <= $signed(bus.multiplicand) * $signed(bus.multiplier);
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy",    {{(2*N-1){1'b0}}, bus.busy}, {{(2*N-1){1'b0}}, (rem > 0)});
            chk("done",    {{(2*N-1){1'b0}}, bus.done}, {{(2*N-1){1'b0}}, exp_done});
            chk("product", bus.product, exp_prod);
        end
    end

    // Present operands with start for one edge, then scramble the operand inputs.
    task automatic launch(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = N'($urandom);
        bus.multiplier   = N'($urandom);
    endtask

    // Called just after the accepting edge; returns at the negedge of the done cycle.
    task automatic wait_done(output int edges, output int busy_n, output bit ok);
        edges  = 1;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic check_done(input string name, input logic [2*N-1:0] exp, input bit chk_lat);
        int  edges;
        int  busy_n;
        bit  ok;
        wait_done(edges, busy_n, ok);
        chk({name, " done seen"}, {{(2*N-1){1'b0}}, ok}, 1);
        if (ok) begin
            chk({name, " product"}, bus.product, exp);
            if (chk_lat) begin
                chk({name, " latency"}, (2*N)'(edges), 5);
                chk({name, " busy cycles"}, (2*N)'(busy_n), 4);
            end
        end
    endtask

    task automatic do_op(input string name, input logic signed [N-1:0] a,
                         input logic signed [N-1:0] b, input logic [2*N-1:0] exp);
        @(posedge clk);
        #1;
        launch(a, b);
        check_done(name, exp, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t, expected under 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [N-1:0]   a;
        logic signed [N-1:0]   b;
        logic signed [2*N-1:0] e;

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy",    {{(2*N-1){1'b0}}, bus.busy}, 0);
        chk("reset done",    {{(2*N-1){1'b0}}, bus.done}, 0);
        chk("reset product", bus.product, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed corner cases with hand-computed results.
        do_op("12*1",      8'sd12,   8'sd1,    16'h000C);
        do_op("-128*-128", -8'sd128, -8'sd128, 16'h4000);
        do_op("127*-128",  8'sd127,  -8'sd128, 16'hC080);
        do_op("0*-77",     8'sd0,    -8'sd77,  16'h0000);

        // Back-to-back: second start issued in the first done cycle.
        do_op("-1*-1",     -8'sd1,   -8'sd1,   16'h0001);
        launch(8'sd5, -8'sd3);
        check_done("b2b 5*-3", 16'hFFF1, 1'b1);

        // A start during RUN must be ignored.
        @(posedge clk);
        #1;
        launch(8'sd9, 8'sd9);
        @(posedge clk);
        #1;
        bus.start        = 1'b1;
        bus.multiplicand = 8'sd2;
        bus.multiplier   = 8'sd2;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        check_done("9*9 ignore", 16'h0051, 1'b0);

        // Reset in the second RUN cycle discards the operation.
        @(posedge clk);
        #1;
        launch(8'sd100, -8'sd55);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun rst busy",    {{(2*N-1){1'b0}}, bus.busy}, 0);
        chk("midrun rst done",    {{(2*N-1){1'b0}}, bus.done}, 0);
        chk("midrun rst product", bus.product, 16'h0000);
        do_op("after rst -7*11", -8'sd7, 8'sd11, 16'hFFB3);

        // Randomized signed pairs with occasional idle gaps and corner values.
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            case ($urandom_range(0, 15))
                0: a = -8'sd128;
                1: b = -8'sd128;
                2: a = 8'sd127;
                3: b = 8'sd0;
                default: ;
            endcase
            e = a * b;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op("random", a, b, e);
        end

        @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/booth4_seq_mult.md
Name: booth4_seq_mult

Overview:
- Sequential signed radix-4 Booth multiplier. It is the control and datapath stage directly upstream of nbit_adder.
- Each cycle it recodes one multiplier bit-triplet, selects 0/±M/±2M as the addend, accumulates it, and shifts.
- Produces a 2N-bit two's-complement product after N/2 iterations.
- Start/busy/done handshake toward the system-level test fixture or host.

Parameters:
- N, 8, operand width in bits; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- multiplicand  input  N  signed operand M; latched on accepted start
- multiplier  input  N  signed operand Q; latched on accepted start
- busy  output  1  high while iterations are in progress
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2N  signed result; held until the next accepted start

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal acc, q, q_m1 and count are cleared.
  - Reset overrides start and any in-flight operation; a reset mid-RUN discards the partial result.
- States:
  - IDLE: wait for start. start=1 -> RUN, latching M, Q, acc=0, q_m1=0, count=0.
  - RUN: one iteration per cycle. After iteration N/2-1 -> DONE.
  - DONE: done=1 and product valid for exactly this cycle. start=1 here -> RUN with new operands (back-to-back). Otherwise -> IDLE.
- busy=1 in every RUN cycle, 0 otherwise. start while busy is ignored; latched operands are unchanged.
- Recoding uses {q[1], q[0], q_m1}:
  - 000 or 111 -> 0
  - 001 or 010 -> +M
  - 011 -> +2M
  - 100 -> -2M
  - 101 or 110 -> -M
- Widths:
  - acc is N+2 bits signed. M is sign-extended to N+2 bits; 2M is the sign-extended M shifted left by 1.
  - -M and -2M are two's complement (invert, +1), so -(-2^(N-1)) is representable.
- Iteration step:
  - sum = acc + addend, modulo 2^(N+2).
  - Then {acc, q, q_m1} arithmetic-shifts right by 2; acc's sign bit is replicated into the two vacated MSBs.
  - count increments.
- Result: product = {acc[N-1:0], q} registered on the RUN->DONE edge. It is exact for all signed operand pairs, including -2^(N-1) * -2^(N-1) = 2^(2N-2).
- Latency:
  - Start sampled at edge k.
  - RUN occupies cycles k+1 .. k+N/2.
  - done is high in cycle k+N/2+1, with product valid there.
  - N=8: 5 cycles from start to done.
- Throughput: one product every N/2+1 cycles with back-to-back starts.
- product keeps its last value through IDLE. It updates only on RUN->DONE or reset.
- Operand inputs may change freely after the start cycle without affecting the result.

Test Plan:
- 12 * 1 (N=8) -> done exactly 5 cycles after start, product=16'h000C; busy high exactly 4 cycles.
- -128 * -128 -> product=16'h4000 (16384). Random signed pairs, 1000 vectors vs reference model -> all match.
- 127 * -128 -> product=16'hC080 (-16256). 0 * -77 -> product=16'h0000.
- -1 * -1 -> 16'h0001. Then start asserted in the DONE cycle with 5 * -3 -> second done 5 cycles later, product=16'hFFF1. First product was visible in its done cycle.
- start pulsed with 9 * 9, then start with 2 * 2 during RUN -> the second start is ignored, product=16'h0051.
- rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, product=0. A new start afterwards computes correctly.
